// File: rtl/mux_41.sv
// 4-to-1 single-bit mux with registered output, select and toggle strobe.
// Optional per-channel saturating select counters when MUX41_STATS_EN is defined.
module mux_41 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0,
  input  logic       s1,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       z0,
  output logic       z0_q,
  output logic [1:0] sel_q,
  output logic       chg
`ifdef MUX41_STATS_EN
  ,
  output logic [CNT_W-1:0] hit0,
  output logic [CNT_W-1:0] hit1,
  output logic [CNT_W-1:0] hit2,
  output logic [CNT_W-1:0] hit3
`endif
);

  // CNT_W only sizes the hit counters, but a zero width is rejected in every build.
  if (CNT_W == 0) begin : g_cnt_w_invalid
    $error("mux_41: CNT_W must be nonzero");
  end

  logic [1:0] sel;
  logic       z0_d;
  logic [1:0] sel_d;
  logic       chg_d;
  logic       chg_q;

  assign sel = {s1, s0};

  always_comb begin
    case (sel)
      2'b00:   z0 = d0;
      2'b01:   z0 = d1;
      2'b10:   z0 = d2;
      default: z0 = d3;
    endcase
  end

  always_comb begin
    z0_d  = z0;
    sel_d = sel;
    chg_d = z0 ^ z0_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z0_q  <= 1'b0;
      sel_q <= 2'b00;
      chg_q <= 1'b0;
    end else begin
      z0_q  <= z0_d;
      sel_q <= sel_d;
      chg_q <= chg_d;
    end
  end

  assign chg = chg_q;

`ifdef MUX41_STATS_EN
  logic [CNT_W-1:0] hit_q [4];
  logic [CNT_W-1:0] hit_d [4];

  always_comb begin
    hit_d = hit_q;
    if (hit_q[sel] != '1) begin
      hit_d[sel] = hit_q[sel] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        hit_q[i] <= '0;
      end
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit0 = hit_q[0];
  assign hit1 = hit_q[1];
  assign hit2 = hit_q[2];
  assign hit3 = hit_q[3];
`endif

endmodule

// File: tb/tb_mux_41.sv
// Self-checking bench for mux_41: directed steps plus random traffic against a behavioural model.
module tb_mux_41;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned HIT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic [3:0] d;
  logic       z0;
  logic       z0_q;
  logic [1:0] sel_q;
  logic       chg;
`ifdef MUX41_STATS_EN
  logic [CNT_W-1:0] hit0, hit1, hit2, hit3;
`endif

  always #5 clk = ~clk;

  mux_41 #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s0    (sel[0]),
    .s1    (sel[1]),
    .d0    (d[0]),
    .d1    (d[1]),
    .d2    (d[2]),
    .d3    (d[3]),
    .z0    (z0),
    .z0_q  (z0_q),
    .sel_q (sel_q),
    .chg   (chg)
`ifdef MUX41_STATS_EN
    ,
    .hit0  (hit0),
    .hit1  (hit1),
    .hit2  (hit2),
    .hit3  (hit3)
`endif
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference state: what the registered outputs should hold after the last edge.
  logic        m_zq;
  logic [1:0]  m_sel;
  logic        m_chg;
  int unsigned m_hit [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the clock edge and check the combinational output.
  task automatic drive(input logic r, input logic [1:0] s, input logic [3:0] dv);
    @(negedge clk);
    rst_n = r;
    sel   = s;
    d     = dv;
    #1;
    check("z0", {31'b0, z0}, {31'b0, dv[s]});
  endtask

  // Advance the model across one rising edge and check the registered outputs.
  task automatic edge_check();
    logic zn;
    @(posedge clk);
    zn = d[sel];
    if (!rst_n) begin
      m_zq  = 1'b0;
      m_sel = 2'b00;
      m_chg = 1'b0;
      for (int i = 0; i < 4; i++) m_hit[i] = 0;
    end else begin
      m_chg = (zn != m_zq);
      m_zq  = zn;
      m_sel = sel;
      if (m_hit[sel] < HIT_MAX) m_hit[sel] = m_hit[sel] + 1;
    end
    #1;
    check("z0_q",  {31'b0, z0_q},  {31'b0, m_zq});
    check("sel_q", {30'b0, sel_q}, {30'b0, m_sel});
    check("chg",   {31'b0, chg},   {31'b0, m_chg});
`ifdef MUX41_STATS_EN
    check("hit0", 32'(hit0), m_hit[0]);
    check("hit1", 32'(hit1), m_hit[1]);
    check("hit2", 32'(hit2), m_hit[2]);
    check("hit3", 32'(hit3), m_hit[3]);
`endif
  endtask

  task automatic cycle(input logic r, input logic [1:0] s, input logic [3:0] dv);
    drive(r, s, dv);
    edge_check();
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 2'b00;
    d     = 4'b0000;

    // Start from a clean reset.
    cycle(1'b0, 2'b00, 4'b0000);

    // Channel 0 follows d0; unselected inputs do not disturb it.
    cycle(1'b1, 2'b00, 4'b0001);
    cycle(1'b1, 2'b00, 4'b0000);
    cycle(1'b1, 2'b00, 4'b1110);
    check("z0_sel00_others", {31'b0, z0}, 32'd0);
    cycle(1'b1, 2'b00, 4'b1111);
    check("z0_sel00_d0hi", {31'b0, z0}, 32'd1);

    // Each remaining channel, data high then low.
    cycle(1'b1, 2'b01, 4'b0010);
    cycle(1'b1, 2'b01, 4'b0000);
    cycle(1'b1, 2'b10, 4'b0100);
    cycle(1'b1, 2'b10, 4'b0000);
    cycle(1'b1, 2'b11, 4'b1000);
    cycle(1'b1, 2'b11, 4'b0000);

    // sel=01 with mixed data: only d1 matters.
    cycle(1'b1, 2'b01, 4'b1011);
    check("z0_mixed_hi", {31'b0, z0}, 32'd1);
    cycle(1'b1, 2'b01, 4'b0100);
    check("z0_mixed_lo", {31'b0, z0}, 32'd0);

    // Reset for two edges with z0=1; z0 stays valid throughout.
    cycle(1'b0, 2'b11, 4'b1000);
    cycle(1'b0, 2'b11, 4'b1000);
    check("z0_in_reset", {31'b0, z0}, 32'd1);
    check("z0_q_in_reset", {31'b0, z0_q}, 32'd0);
    cycle(1'b1, 2'b11, 4'b1000);
    check("chg_after_release", {31'b0, chg}, 32'd1);
    cycle(1'b1, 2'b11, 4'b1000);
    check("chg_settled", {31'b0, chg}, 32'd0);

    // Toggling d3 every cycle strobes chg every cycle.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 2'b11, (i % 2 == 0) ? 4'b0000 : 4'b1000);
      check("chg_toggle", {31'b0, chg}, 32'd1);
    end

`ifdef MUX41_STATS_EN
    // Saturation of a single channel counter.
    cycle(1'b0, 2'b10, 4'b0000);
    for (int i = 0; i < 20; i++) cycle(1'b1, 2'b10, 4'(i));
    check("hit2_saturated", 32'(hit2), 32'd15);
    cycle(1'b0, 2'b10, 4'b0000);
    check("hit2_cleared", 32'(hit2), 32'd0);
`endif

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
